// File: rtl/line_buffer_writer.sv
// Line buffer writer: captures one packed multi-beat line, serialises it into a
// beat-wide buffer with a per-beat valid bitmap, and serves registered lookups.
module line_buffer_writer #(
  parameter int DATA_WIDTH = 128,
  parameter int LINE_BEATS = 4,
  parameter int ADDR_WIDTH = 40,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = 8,
  parameter int CNT_W      = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ad_valid,
  input  logic [ADDR_WIDTH-1:0]            ad_addr,
  input  logic [DATA_WIDTH*LINE_BEATS-1:0] ad_data,
  output logic                             ad_done,
  input  logic                             inv_all,
  input  logic                             lk_req,
  input  logic [IDX_W-1:0]                 lk_idx,
  output logic                             lk_ack,
  output logic                             lk_hit,
  output logic [DATA_WIDTH-1:0]            lk_data,
  output logic                             busy,
  output logic [CNT_W-1:0]                 lines_written
);

  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE, RELEASE} state_t;

  state_t                             state;
  logic [DATA_WIDTH*LINE_BEATS-1:0]   shadow;
  logic [IDX_W-1:0]                   base;
  logic [BEAT_W-1:0]                  beat;
  logic [MEM_DEPTH-1:0]               valid;
  logic [DATA_WIDTH-1:0]              mem [MEM_DEPTH];

  logic                               wr_en;
  logic [IDX_W-1:0]                   wr_idx;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic                               addr_unused;

  // Only the low IDX_W address bits select a buffer slot; the rest are ignored.
  assign addr_unused = ^ad_addr[ADDR_WIDTH-1:IDX_W];

  assign wr_en   = (state == WRITE) && !reset;
  assign wr_idx  = base + IDX_W'(beat);
  assign wr_data = shadow[beat*DATA_WIDTH +: DATA_WIDTH];

  // NOTE: the buffer array has no reset so it maps onto block RAM; the valid bitmap alone says what is live.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Line payload and base are pure datapath, sampled only at capture.
  always_ff @(posedge clock) begin
    if (state == IDLE && ad_valid) begin
      shadow <= ad_data;
      base   <= ad_addr[IDX_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      busy          <= 1'b0;
      ad_done       <= 1'b0;
      lines_written <= '0;
      valid         <= '0;
      lk_ack        <= 1'b0;
      lk_hit        <= 1'b0;
      lk_data       <= '0;
    end else begin
      ad_done <= 1'b0;
      case (state)
        IDLE: if (ad_valid) begin
          beat  <= '0;
          busy  <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          beat <= beat + 1'b1;
          if (beat == LAST_BEAT) begin
            ad_done <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (lines_written != '1) lines_written <= lines_written + 1'b1;
          state <= RELEASE;
        end
        RELEASE: if (!ad_valid) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // NOTE: non-blocking updates resolve in order, so a beat written this cycle survives a same-cycle clear.
      if (inv_all) valid <= '0;
      if (wr_en)   valid[wr_idx] <= 1'b1;

      // Read-first: both reads see the state before this cycle's write.
      lk_ack <= lk_req;
      if (lk_req) begin
        lk_hit  <= valid[lk_idx];
        lk_data <= mem[lk_idx];
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_writer.sv
// Self-checking bench for line_buffer_writer: lookup table vectors scored
// through an expected-result queue, plus hand-built multi-cycle sequences.
module tb_line_buffer_writer;

  localparam int DW = 128;
  localparam int LB = 4;
  localparam int AW = 40;
  localparam int IW = 8;
  localparam int CW = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ad_valid = 1'b0;
  logic [AW-1:0]     ad_addr = '0;
  logic [DW*LB-1:0]  ad_data = '0;
  logic              ad_done;
  logic              inv_all = 1'b0;
  logic              lk_req = 1'b0;
  logic [IW-1:0]     lk_idx = '0;
  logic              lk_ack;
  logic              lk_hit;
  logic [DW-1:0]     lk_data;
  logic              busy;
  logic [CW-1:0]     lines_written;

  line_buffer_writer dut (
    .clock(clock), .reset(reset),
    .ad_valid(ad_valid), .ad_addr(ad_addr), .ad_data(ad_data), .ad_done(ad_done),
    .inv_all(inv_all), .lk_req(lk_req), .lk_idx(lk_idx),
    .lk_ack(lk_ack), .lk_hit(lk_hit), .lk_data(lk_data),
    .busy(busy), .lines_written(lines_written)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            due;
    logic          hit;
    logic          chk;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic          hit;
    logic          chk;
    logic [DW-1:0] data;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   exp_lines = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Output monitor: counts ad_done pulses and scores every lookup response.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (ad_done) done_cnt++;
    if (lk_ack) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL lk_ack_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("lk_ack_cycle", cyc, e.due);
        check("lk_hit", lk_hit, e.hit);
        if (e.chk) check("lk_data", lk_data, e.data);
      end
    end
  end

  function automatic logic [DW-1:0] bt(input logic [7:0] tag, input int k);
    return {4{tag, 8'(k), 16'hc0de}};
  endfunction

  function automatic logic [DW*LB-1:0] line(input logic [7:0] tag);
    return {bt(tag, 3), bt(tag, 2), bt(tag, 1), bt(tag, 0)};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      lk_req  = 1'b0;
      inv_all = 1'b0;
    end
  endtask

  task automatic lookup(input logic [IW-1:0] idx, input logic hit, input logic chk, input logic [DW-1:0] data);
    @(posedge clock); #1;
    lk_req = 1'b1;
    lk_idx = idx;
    sb.push_back('{cyc + 1, hit, chk, data});
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) lookup(tbl[i].idx, tbl[i].hit, tbl[i].chk, tbl[i].data);
    idle(3);
    tbl.delete();
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    ad_valid = 1'b0;
    lk_req = 1'b0;
    inv_all = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_lines = 0;
  endtask

  // Sends one line, holds ad_valid `hold` cycles past ad_done, optionally pulses
  // inv_all at step inv_at and issues a read-first lookup pair at lk_at/lk_at+1.
  task automatic send_line(input logic [AW-1:0] addr, input logic [DW*LB-1:0] data, input int hold,
                           input int inv_at, input int lk_at, input logic [IW-1:0] lk_i,
                           input logic old_h, input logic [DW-1:0] old_d, input logic [DW-1:0] new_d);
    int c, lat, d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    lat = -1;
    @(posedge clock); #1;
    ad_valid = 1'b1;
    ad_addr  = addr;
    ad_data  = data;
    lk_req   = 1'b0;
    c = cyc;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clock); #1;
      ad_data = ~data;
      ad_addr = addr ^ 40'h55;
      inv_all = (k == inv_at);
      lk_req  = 1'b0;
      if (k == lk_at) begin
        lk_req = 1'b1;
        lk_idx = lk_i;
        sb.push_back('{cyc + 1, old_h, 1'b1, old_d});
      end
      if (k == lk_at + 1) begin
        lk_req = 1'b1;
        lk_idx = lk_i;
        sb.push_back('{cyc + 1, 1'b1, 1'b1, new_d});
      end
      @(negedge clock);
      if (k == 2) check("busy_in_write", busy, 1);
      if (ad_done) begin
        seen = 1;
        lat = cyc - c;
      end
    end
    check("ad_done_latency", lat, 5);
    repeat (hold) begin
      @(posedge clock); #1;
      inv_all = 1'b0;
      lk_req  = 1'b0;
    end
    @(posedge clock); #1;
    ad_valid = 1'b0;
    inv_all  = 1'b0;
    lk_req   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("busy_after_release", busy, 0);
    exp_lines++;
    check("lines_written", lines_written, exp_lines);
    idle(4);
    check("single_ad_done", done_cnt - d0, 1);
  endtask

  initial begin : timeout
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int c, d0;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ad_done", ad_done, 0);
    check("rst_lk_ack", lk_ack, 0);
    check("rst_lk_hit", lk_hit, 0);
    check("rst_busy", busy, 0);
    check("rst_lk_data", lk_data, 0);
    check("rst_lines_written", lines_written, 0);

    // Basic line at 0x10.
    send_line(40'h10, line(8'hA0), 0, -10, -10, 8'h0, 1'b0, '0, '0);
    tbl.push_back('{8'h10, 1'b1, 1'b1, bt(8'hA0, 0)});
    tbl.push_back('{8'h11, 1'b1, 1'b1, bt(8'hA0, 1)});
    tbl.push_back('{8'h12, 1'b1, 1'b1, bt(8'hA0, 2)});
    tbl.push_back('{8'h13, 1'b1, 1'b1, bt(8'hA0, 3)});
    tbl.push_back('{8'h14, 1'b0, 1'b0, '0});
    run_table();

    // Wrap around the top of the buffer; upper address bits ignored.
    send_line(40'hAB_0000_00FE, line(8'hB0), 0, -10, -10, 8'h0, 1'b0, '0, '0);
    tbl.push_back('{8'hFE, 1'b1, 1'b1, bt(8'hB0, 0)});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, bt(8'hB0, 1)});
    tbl.push_back('{8'h00, 1'b1, 1'b1, bt(8'hB0, 2)});
    tbl.push_back('{8'h01, 1'b1, 1'b1, bt(8'hB0, 3)});
    tbl.push_back('{8'h02, 1'b0, 1'b0, '0});
    tbl.push_back('{8'h10, 1'b1, 1'b1, bt(8'hA0, 0)});
    run_table();

    // ad_valid held past ad_done: one capture only, then a second line.
    do_reset();
    send_line(40'h20, line(8'hC0), 3, -10, -10, 8'h0, 1'b0, '0, '0);
    send_line(40'h30, line(8'hC1), 0, -10, -10, 8'h0, 1'b0, '0, '0);
    tbl.push_back('{8'h20, 1'b1, 1'b1, bt(8'hC0, 0)});
    tbl.push_back('{8'h33, 1'b1, 1'b1, bt(8'hC1, 3)});
    tbl.push_back('{8'h10, 1'b0, 1'b0, '0});
    run_table();

    // inv_all in the cycle beat 2 is written.
    send_line(40'h40, line(8'hC2), 0, 3, -10, 8'h0, 1'b0, '0, '0);
    tbl.push_back('{8'h40, 1'b0, 1'b1, bt(8'hC2, 0)});
    tbl.push_back('{8'h41, 1'b0, 1'b1, bt(8'hC2, 1)});
    tbl.push_back('{8'h42, 1'b1, 1'b1, bt(8'hC2, 2)});
    tbl.push_back('{8'h43, 1'b1, 1'b1, bt(8'hC2, 3)});
    tbl.push_back('{8'h20, 1'b0, 1'b1, bt(8'hC0, 0)});
    run_table();

    // Read-first: index 5 holds stale data with its valid bit cleared, then is rewritten.
    send_line(40'h02, line(8'hC3), 0, -10, -10, 8'h0, 1'b0, '0, '0);
    @(posedge clock); #1 inv_all = 1'b1;
    idle(2);
    send_line(40'h05, line(8'hC4), 0, -10, 1, 8'h05, 1'b0, bt(8'hC3, 3), bt(8'hC4, 0));
    tbl.push_back('{8'h08, 1'b1, 1'b1, bt(8'hC4, 3)});
    tbl.push_back('{8'h04, 1'b0, 1'b1, bt(8'hC3, 2)});
    run_table();

    // Reset during WRITE beat 1 aborts the line.
    d0 = done_cnt;
    @(posedge clock); #1;
    ad_valid = 1'b1;
    ad_addr  = 40'h80;
    ad_data  = line(8'hD0);
    c = cyc;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    ad_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_lines = 0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_lines_written", lines_written, 0);
    idle(8);
    check("abort_no_ad_done", done_cnt - d0, 0);
    tbl.push_back('{8'h80, 1'b0, 1'b0, '0});
    tbl.push_back('{8'h81, 1'b0, 1'b0, '0});
    tbl.push_back('{8'h82, 1'b0, 1'b0, '0});
    tbl.push_back('{8'h83, 1'b0, 1'b0, '0});
    tbl.push_back('{8'h08, 1'b0, 1'b0, '0});
    run_table();

    send_line(40'h80, line(8'hE0), 0, -10, -10, 8'h0, 1'b0, '0, '0);
    tbl.push_back('{8'h80, 1'b1, 1'b1, bt(8'hE0, 0)});
    tbl.push_back('{8'h83, 1'b1, 1'b1, bt(8'hE0, 3)});
    tbl.push_back('{8'h84, 1'b0, 1'b0, '0});
    run_table();

    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
